// File: rtl/bicubic_pkg.sv
// Shared constants for the bicubic SIMD accumulator slice.
//   COEFF_FRAC_BITS : fractional bits of the bicubic coefficients (result scale)
//   LANE_W          : signed width of one unpacked lane beat
//   ACC_W           : signed accumulator width (holds a full 4-tap sum)
//   PIX_W           : output pixel width
//   DSP_W           : width of one core's packed two-lane DSP product
package bicubic_pkg;
    localparam int COEFF_FRAC_BITS = 7;
    localparam int LANE_W          = 18;
    localparam int ACC_W           = 20;
    localparam int PIX_W           = 8;
    localparam int DSP_W           = 48;
    // Half an output LSB, added before the shift for round-half-up.
    localparam int RND_HALF        = 1 << (COEFF_FRAC_BITS - 1);
endpackage

// File: rtl/bicubic_lane_acc.sv
// One lane of the bicubic accumulator: sums tap-pair beats into a full sum,
// then rounds, scales and clamps that sum into an unsigned pixel.
// Ports:
//   clk, aresetn : clock, async active-low reset
//   i_clken      : global clock enable (freezes all state when low)
//   i_clr        : discard the partial accumulation
//   i_beat       : accepted beat this cycle (already excludes i_clr)
//   i_first      : beat is the first of a result (overwrite, not add)
//   i_last       : beat is the last of a result (capture the sum)
//   i_sum_v      : captured sum is valid; update the pixel
//   i_lane       : signed lane value of the current beat
//   o_pix        : registered clamped pixel
module bicubic_lane_acc
    import bicubic_pkg::*;
(
    input  logic                     clk,
    input  logic                     aresetn,
    input  logic                     i_clken,
    input  logic                     i_clr,
    input  logic                     i_beat,
    input  logic                     i_first,
    input  logic                     i_last,
    input  logic                     i_sum_v,
    input  logic signed [LANE_W-1:0] i_lane,
    output logic        [PIX_W-1:0]  o_pix
);
    localparam logic signed [ACC_W:0] RND = (ACC_W+1)'(RND_HALF);

    logic signed [ACC_W-1:0] r_acc, r_sum;
    logic        [PIX_W-1:0] r_pix;
    logic signed [ACC_W-1:0] w_base, w_next;
    logic signed [ACC_W:0]   w_ext, w_rnd;
    logic        [PIX_W-1:0] w_pix;

    always_comb begin
        // Folding the first-beat overwrite into the base also covers TAP_PAIRS=1,
        // where the same beat is both first and last.
        w_base = i_first ? '0 : r_acc;
        w_next = w_base + {{(ACC_W-LANE_W){i_lane[LANE_W-1]}}, i_lane};
        // One guard bit so the rounding add cannot wrap at the accumulator limit.
        w_ext  = {r_sum[ACC_W-1], r_sum};
        w_rnd  = (w_ext + RND) >>> COEFF_FRAC_BITS;
        if (w_rnd[ACC_W])
            w_pix = '0;
        else if (|w_rnd[ACC_W-1:PIX_W])
            w_pix = '1;
        else
            w_pix = w_rnd[PIX_W-1:0];
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_acc <= '0;
            r_sum <= '0;
            r_pix <= '0;
        end else if (i_clken) begin
            if (i_clr) begin
                r_acc <= '0;
            end else if (i_beat) begin
                r_acc <= w_next;
                if (i_last)
                    r_sum <= w_next;
            end
            if (i_sum_v)
                r_pix <= w_pix;
        end
    end

    assign o_pix = r_pix;
endmodule

// File: rtl/bicubic_nx_simd_acc.sv
// N-core SIMD bicubic accumulator. Unpacks each core's two-lane DSP product,
// accumulates TAP_PAIRS beats per result and emits two clamped UINT8 pixels
// per core with a single-cycle dout_valid strobe.
// Ports:
//   clk, aresetn : clock, async active-low reset
//   clken        : global clock enable; low freezes every register
//   sync_clear   : abort the partial result (a completed sum still drains)
//   din_valid    : din carries one tap-pair beat
//   din          : per core i, packed product in [48i+47:48i]
//   dout_valid   : result strobe (hold while clken is low)
//   dout_a       : high-lane pixel per core, [8i+7:8i]
//   dout_b       : low-lane pixel per core, [8i+7:8i]
module bicubic_nx_simd_acc
    import bicubic_pkg::*;
#(
    parameter int PARALLEL_CORE = 8,
    parameter int TAP_PAIRS     = 2
) (
    input  logic                             clk,
    input  logic                             aresetn,
    input  logic                             clken,
    input  logic                             sync_clear,
    input  logic                             din_valid,
    input  logic [PARALLEL_CORE*DSP_W-1:0]   din,
    output logic                             dout_valid,
    output logic [PARALLEL_CORE*PIX_W-1:0]   dout_a,
    output logic [PARALLEL_CORE*PIX_W-1:0]   dout_b
);
    localparam int PH_W = (TAP_PAIRS > 1) ? $clog2(TAP_PAIRS) : 1;

    logic [PH_W-1:0] r_ph;
    logic            r_sum_v;
    logic            r_dout_valid;
    logic            w_beat, w_first, w_last;

    logic [2*PARALLEL_CORE-1:0][LANE_W-1:0] w_lane;
    logic [2*PARALLEL_CORE-1:0][PIX_W-1:0]  w_pix;

    // sync_clear wins over a coincident beat, so the beat is simply dropped.
    assign w_beat  = din_valid & ~sync_clear;
    assign w_first = (r_ph == '0);
    assign w_last  = (r_ph == PH_W'(TAP_PAIRS-1));

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_ph         <= '0;
            r_sum_v      <= 1'b0;
            r_dout_valid <= 1'b0;
        end else if (clken) begin
            if (sync_clear)
                r_ph <= '0;
            else if (din_valid)
                r_ph <= w_last ? '0 : r_ph + 1'b1;
            // A valid sum is always consumed on an enabled edge, so the flag
            // only survives if a new final beat lands on that same edge.
            r_sum_v      <= w_beat & w_last;
            r_dout_valid <= r_sum_v;
        end
    end

    for (genvar c = 0; c < PARALLEL_CORE; c++) begin : g_core
        logic [DSP_W-2*LANE_W-1:0] w_unused_top;

        // Low lane is plain; a negative low lane borrowed one from the high
        // field, so add its sign bit back (result truncated to LANE_W).
        assign w_lane[2*c]   = din[DSP_W*c +: LANE_W];
        assign w_lane[2*c+1] = din[DSP_W*c+LANE_W +: LANE_W]
                             + LANE_W'(din[DSP_W*c+LANE_W-1]);
        // Bits above the high lane only carry its sign extension.
        assign w_unused_top  = din[DSP_W*c+2*LANE_W +: DSP_W-2*LANE_W];

        for (genvar l = 0; l < 2; l++) begin : g_lane
            bicubic_lane_acc u_lane (
                .clk     (clk),
                .aresetn (aresetn),
                .i_clken (clken),
                .i_clr   (sync_clear),
                .i_beat  (w_beat),
                .i_first (w_first),
                .i_last  (w_last),
                .i_sum_v (r_sum_v),
                .i_lane  (w_lane[2*c+l]),
                .o_pix   (w_pix[2*c+l])
            );
        end

        assign dout_b[PIX_W*c +: PIX_W] = w_pix[2*c];
        assign dout_a[PIX_W*c +: PIX_W] = w_pix[2*c+1];
    end

    assign dout_valid = r_dout_valid;
endmodule
